alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_cmp.sv | 14 +
 rtl/alu_core.sv | 68 ++++++
 tb/tb_alu_core.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and default data width.
// Ops 110/111 become XOR/SRA only when ALU_EXT_OPS_EN is defined.
package alu_pkg;

  localparam int ALU_DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_SLT  = 3'b100,
    OP_SLTU = 3'b101,
    OP_XOR  = 3'b110,
    OP_SRA  = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_cmp.sv
// Combinational magnitude comparator feeding the SLT/SLTU operations.
module alu_cmp #(
  parameter int WIDTH = alu_pkg::ALU_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt_signed,
  output logic             lt_unsigned
);

  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

endmodule

// File: rtl/alu_core.sv
// Single-cycle registered ALU with synchronous active-high reset.
// Define ALU_EXT_OPS_EN to enable XOR (110) and arithmetic right shift (111).
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic             lt_signed;
  logic             lt_unsigned;
  logic [WIDTH-1:0] next_result;

  alu_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a           (a),
    .b           (b),
    .lt_signed   (lt_signed),
    .lt_unsigned (lt_unsigned)
  );

`ifdef ALU_EXT_OPS_EN
  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic [WIDTH-1:0] sra_result;
  assign sra_result = WIDTH'($signed(a) >>> b[SHW-1:0]);
`endif

  always_comb begin
    next_result = '0;
    case (alu_op_e'(alu_op))
      OP_ADD:  next_result = a + b;
      OP_SUB:  next_result = a - b;
      OP_AND:  next_result = a & b;
      OP_OR:   next_result = a | b;
      OP_SLT:  next_result = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: next_result = {{(WIDTH-1){1'b0}}, lt_unsigned};
`ifdef ALU_EXT_OPS_EN
      OP_XOR:  next_result = a ^ b;
      OP_SRA:  next_result = sra_result;
`endif
      default: next_result = '0;
    endcase
  end

  // zero is registered alongside result so the pair can never disagree
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= next_result;
        zero   <= (next_result == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed literal cases plus randomized
// traffic compared every cycle against a behavioural model (ALU_EXT_OPS_EN aware).
module tb_alu_core;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alu_op;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_result;
  logic             exp_zero;
  logic             exp_valid;
  bit               model_ready = 0;

  alu_core #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference arithmetic taken straight from the operation table
  function automatic logic [WIDTH-1:0] refOp(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic [2:0] op);
    int sx;
    int sy;
    sx = x;
    sy = y;
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return (sx < sy) ? 32'd1 : 32'd0;
      3'd5: return (x < y) ? 32'd1 : 32'd0;
`ifdef ALU_EXT_OPS_EN
      3'd6: return x ^ y;
      3'd7: return sx >>> (y % 32);
`endif
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_result = '0;
      exp_zero   = 1'b1;
      exp_valid  = 1'b0;
    end else begin
      exp_valid = in_valid;
      if (in_valid) begin
        exp_result = refOp(a, b, alu_op);
        exp_zero   = (exp_result == '0);
      end
    end
    model_ready = 1;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      checks++;
      if (result !== exp_result || zero !== exp_zero || out_valid !== exp_valid) begin
        errors++;
        $display("[TB] FAIL model t=%0t result=%h zero=%b valid=%b required result=%h zero=%b valid=%b",
                 $time, result, zero, out_valid, exp_result, exp_zero, exp_valid);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic v, input logic [WIDTH-1:0] x,
                               input logic [WIDTH-1:0] y, input logic [2:0] op);
    rst      = r;
    in_valid = v;
    a        = x;
    b        = y;
    alu_op   = op;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] r,
                             input logic z, input logic v);
    checks++;
    if (result !== r || zero !== z || out_valid !== v) begin
      errors++;
      $display("[TB] FAIL %s: result=%h zero=%b valid=%b required result=%h zero=%b valid=%b",
               name, result, zero, out_valid, r, z, v);
    end
  endtask

  function automatic logic [WIDTH-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [WIDTH-1:0] ext_xor;
    logic [WIDTH-1:0] ext_sra;
    logic             ext_xor_zero;
    logic             ext_sra_zero;
`ifdef ALU_EXT_OPS_EN
    ext_xor = 32'h0000_000F;
    ext_sra = 32'hF800_0000;
`else
    ext_xor = '0;
    ext_sra = '0;
`endif
    ext_xor_zero = (ext_xor == '0);
    ext_sra_zero = (ext_sra == '0);

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_op = 3'd0;
    applyStimulus(1, 0, 0, 0, 3'd0);
    applyStimulus(1, 0, 0, 0, 3'd0);
    checkOutput("reset", 32'd0, 1'b1, 1'b0);

    applyStimulus(0, 1, 32'd10, 32'd5, 3'd0);
    checkOutput("add", 32'd15, 1'b0, 1'b1);
    applyStimulus(0, 1, -32'sd5, 32'd3, 3'd1);
    checkOutput("sub_neg", 32'hFFFF_FFF8, 1'b0, 1'b1);
    applyStimulus(0, 1, 32'd8, 32'd3, 3'd2);
    checkOutput("and_zero", 32'd0, 1'b1, 1'b1);
    applyStimulus(0, 1, 32'd5, 32'd3, 3'd3);
    checkOutput("or", 32'd7, 1'b0, 1'b1);
    applyStimulus(0, 1, -32'sd10, 32'd15, 3'd4);
    checkOutput("slt", 32'd1, 1'b0, 1'b1);
    applyStimulus(0, 1, -32'sd10, 32'd15, 3'd5);
    checkOutput("sltu", 32'd0, 1'b1, 1'b1);
    applyStimulus(0, 1, 32'hFFFF_FFFF, 32'd1, 3'd0);
    checkOutput("add_wrap", 32'd0, 1'b1, 1'b1);
    applyStimulus(0, 1, 32'h8000_0000, 32'd1, 3'd1);
    checkOutput("sub_wrap", 32'h7FFF_FFFF, 1'b0, 1'b1);
    applyStimulus(0, 1, 32'h0000_00F0, 32'h0000_00FF, 3'd6);
    checkOutput("op110", ext_xor, ext_xor_zero, 1'b1);
    applyStimulus(0, 1, 32'h8000_0000, 32'h0000_0024, 3'd7);
    checkOutput("op111", ext_sra, ext_sra_zero, 1'b1);

    applyStimulus(0, 1, 32'd100, 32'd23, 3'd0);
    checkOutput("pre_hold", 32'd123, 1'b0, 1'b1);
    applyStimulus(0, 0, 32'd1, 32'd1, 3'd1);
    checkOutput("hold1", 32'd123, 1'b0, 1'b0);
    applyStimulus(0, 0, 32'd7, 32'd9, 3'd3);
    checkOutput("hold2", 32'd123, 1'b0, 1'b0);
    applyStimulus(0, 1, 32'd2, 32'd2, 3'd1);
    checkOutput("resume", 32'd0, 1'b1, 1'b1);

    applyStimulus(0, 1, 32'd40, 32'd2, 3'd0);
    applyStimulus(1, 1, 32'd3, 32'd4, 3'd0);
    checkOutput("rst_priority", 32'd0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                    pickOperand(), pickOperand(), 3'($urandom_range(0, 7)));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
